// File: rtl/score_display_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the score display controller.
package score_display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam logic [7:0] DP_NORMAL  = 8'b1100_0000;
    localparam logic [7:0] DP_FLASH   = 8'hFF;
    localparam int         BCD_DIGITS = 5;
    localparam int         BCD_W      = 4 * BCD_DIGITS;
    localparam int         SHIFT_CNT  = 16;

    // A single display digit cannot show more than 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] value);
        return (value > 4'd9) ? 4'd9 : value;
    endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Valid/ready score transfer from the game logic into the display controller.
interface score_display_ctrl_if #(
    parameter int SCORE_W = 16
);

    logic [SCORE_W-1:0] score_in;
    logic               score_valid;
    logic               score_ready;

    modport master (
        output score_in,
        output score_valid,
        input  score_ready
    );

    modport slave (
        input  score_in,
        input  score_valid,
        output score_ready
    );

endinterface

// File: rtl/score_display_ctrl_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, SHIFT_CNT shifts per start.
module bin2bcd_seq
    import score_display_ctrl_pkg::*;
#(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    localparam int                CNT_W    = $clog2(SHIFT_CNT + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SHIFT_CNT - 1);

    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] bit_cnt;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            bin_sr  <= bin_in;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
            bit_cnt          <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_CNT) begin
                busy <= 1'b0;
            end
        end
    end

    // Flags the cycle of the final shift; bcd_out holds the result from the next cycle.
    assign done    = busy && (bit_cnt == LAST_CNT);
    assign bcd_out = bcd_sr;

endmodule

// File: rtl/score_display_ctrl.sv
// Feeds the 8-digit seven-segment mux: lives, level, 5-digit BCD score and flashing decimal points.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int SCORE_W      = 16,
    parameter int FLASH_HALF   = 12_500_000,
    parameter int FLASH_PHASES = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    score_display_ctrl_if.slave  score_bus,
    input  logic [3:0]           lives_in,
    input  logic [3:0]           level_in,
    input  logic                 flash_req,
    output logic [3:0]           hex7,
    output logic [3:0]           hex6,
    output logic [3:0]           hex5,
    output logic [3:0]           hex4,
    output logic [3:0]           hex3,
    output logic [3:0]           hex2,
    output logic [3:0]           hex1,
    output logic [3:0]           hex0,
    output logic [7:0]           dp_out
);

    localparam int               PH_W     = $clog2(FLASH_PHASES + 1);
    localparam int               CYC_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(FLASH_PHASES);
    localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(FLASH_HALF - 1);

    conv_state_t      state;
    logic             ready_q;
    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_W-1:0] score_digits;

    logic [PH_W-1:0]  phase_cnt;
    logic [PH_W-1:0]  phase_next;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_next;

    assign score_bus.score_ready = ready_q;
    assign conv_start = (state == ST_IDLE) && score_bus.score_valid && ready_q && !conv_busy;

    bin2bcd_seq #(
        .BIN_W (SCORE_W)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (conv_start),
        .bin_in  (score_bus.score_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    // Displayed digits only change in COMMIT, so a conversion in flight is never visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            ready_q      <= 1'b1;
            score_digits <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (conv_start) begin
                        state   <= ST_SHIFT;
                        ready_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (conv_done) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    score_digits <= conv_bcd;
                    ready_q      <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex7 <= 4'd0;
            hex6 <= 4'd0;
        end else begin
            hex7 <= clamp_digit(lives_in);
            hex6 <= clamp_digit(level_in);
        end
    end

    assign hex5 = 4'd0;
    assign {hex4, hex3, hex2, hex1, hex0} = score_digits;

    always_comb begin
        phase_next = phase_cnt;
        cyc_next   = cyc_cnt;
        if (flash_req) begin
            phase_next = PH_LOAD;
            cyc_next   = CYC_LOAD;
        end else if (phase_cnt != '0) begin
            if (cyc_cnt == '0) begin
                cyc_next   = CYC_LOAD;
                phase_next = phase_cnt - 1'b1;
            end else begin
                cyc_next = cyc_cnt - 1'b1;
            end
        end
    end

    // Lit while the count of phases still to follow the current one is odd, so the first phase is lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            cyc_cnt   <= '0;
            dp_out    <= DP_NORMAL;
        end else begin
            phase_cnt <= phase_next;
            cyc_cnt   <= cyc_next;
            dp_out    <= ((phase_next != '0) && !phase_next[0]) ? DP_FLASH : DP_NORMAL;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed self-checking bench for score_display_ctrl with a short flash timer.
module tb_score_display_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] lives_in;
    logic [3:0] level_in;
    logic       flash_req;
    logic [3:0] hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
    logic [7:0] dp_out;
    logic [19:0] score_digits;
    logic [31:0] all_hex;

    int checks_done = 0;
    int checks_failed = 0;

    score_display_ctrl_if #(.SCORE_W(16)) score_bus ();

    score_display_ctrl #(
        .SCORE_W      (16),
        .FLASH_HALF   (4),
        .FLASH_PHASES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .score_bus (score_bus),
        .lives_in  (lives_in),
        .level_in  (level_in),
        .flash_req (flash_req),
        .hex7      (hex7),
        .hex6      (hex6),
        .hex5      (hex5),
        .hex4      (hex4),
        .hex3      (hex3),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0),
        .dp_out    (dp_out)
    );

    always #5 clk = ~clk;

    assign score_digits = {hex4, hex3, hex2, hex1, hex0};
    assign all_hex      = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] score, input logic valid,
                                 input logic [3:0] lives, input logic [3:0] level,
                                 input logic flash);
        score_bus.score_in    = score;
        score_bus.score_valid = valid;
        lives_in              = lives;
        level_in              = level;
        flash_req             = flash;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(16'd0, 1'b0, 4'd0, 4'd0, 1'b0);
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("reset_hex", all_hex, 32'h0);
        checkOutput("reset_dp", {24'h0, dp_out}, 32'hC0);
        checkOutput("reset_ready", {31'h0, score_bus.score_ready}, 32'h1);

        // Lives/level clamping with one-cycle latency
        applyStimulus(16'd0, 1'b0, 4'd12, 4'd3, 1'b0);
        tick();
        checkOutput("lives_clamp", {28'h0, hex7}, 32'h9);
        checkOutput("level_pass", {28'h0, hex6}, 32'h3);
        checkOutput("hex5_zero", {28'h0, hex5}, 32'h0);
        applyStimulus(16'd0, 1'b0, 4'd5, 4'd10, 1'b0);
        checkOutput("lives_latency", {28'h0, hex7}, 32'h9);
        tick();
        checkOutput("lives_5", {28'h0, hex7}, 32'h5);
        checkOutput("level_clamp", {28'h0, hex6}, 32'h9);

        // 65535 then 0 back-to-back with valid held high
        applyStimulus(16'd65535, 1'b1, 4'd5, 4'd10, 1'b0);
        tick();
        checkOutput("b2b_ready_low", {31'h0, score_bus.score_ready}, 32'h0);
        score_bus.score_in = 16'd0;
        repeat (16) tick();
        checkOutput("b2b_no_partial", {12'h0, score_digits}, 32'h0);
        checkOutput("b2b_busy_t16", {31'h0, score_bus.score_ready}, 32'h0);
        tick();
        checkOutput("digits_65535", {12'h0, score_digits}, 32'h65535);
        checkOutput("ready_t17", {31'h0, score_bus.score_ready}, 32'h1);
        tick();
        checkOutput("b2b_accept_t18", {31'h0, score_bus.score_ready}, 32'h0);
        checkOutput("b2b_hold_65535", {12'h0, score_digits}, 32'h65535);
        score_bus.score_valid = 1'b0;
        repeat (16) tick();
        checkOutput("b2b2_no_partial", {12'h0, score_digits}, 32'h65535);
        tick();
        checkOutput("digits_zero", {12'h0, score_digits}, 32'h0);
        checkOutput("ready_after_zero", {31'h0, score_bus.score_ready}, 32'h1);

        // 12345 with valid for one cycle: ready low 17 cycles
        applyStimulus(16'd12345, 1'b1, 4'd5, 4'd10, 1'b0);
        tick();
        applyStimulus(16'd12345, 1'b0, 4'd5, 4'd10, 1'b0);
        checkOutput("busy_t0", {31'h0, score_bus.score_ready}, 32'h0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            checkOutput($sformatf("busy_t%0d", i), {31'h0, score_bus.score_ready}, 32'h0);
        end
        tick();
        checkOutput("digits_12345", {12'h0, score_digits}, 32'h12345);
        checkOutput("ready_12345", {31'h0, score_bus.score_ready}, 32'h1);

        // Single flash: FF for 4 cycles, then C0
        tick();
        applyStimulus(16'd0, 1'b0, 4'd5, 4'd10, 1'b1);
        tick();
        flash_req = 1'b0;
        checkOutput("flash_c0", {24'h0, dp_out}, 32'hFF);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("flash_c%0d", i), {24'h0, dp_out}, 32'hFF);
        end
        for (int i = 4; i <= 9; i++) begin
            tick();
            checkOutput($sformatf("flash_off_c%0d", i), {24'h0, dp_out}, 32'hC0);
        end

        // Restart at cycle 2 of the flash
        flash_req = 1'b1;
        tick();
        flash_req = 1'b0;
        checkOutput("restart_c0", {24'h0, dp_out}, 32'hFF);
        tick();
        checkOutput("restart_c1", {24'h0, dp_out}, 32'hFF);
        flash_req = 1'b1;
        tick();
        flash_req = 1'b0;
        checkOutput("restart_r0", {24'h0, dp_out}, 32'hFF);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("restart_r%0d", i), {24'h0, dp_out}, 32'hFF);
        end
        tick();
        checkOutput("restart_off", {24'h0, dp_out}, 32'hC0);
        repeat (8) tick();

        // Flash together with a transfer, then async reset mid-conversion of 999
        applyStimulus(16'd999, 1'b1, 4'd5, 4'd10, 1'b1);
        tick();
        applyStimulus(16'd999, 1'b0, 4'd5, 4'd10, 1'b0);
        checkOutput("joint_ready", {31'h0, score_bus.score_ready}, 32'h0);
        checkOutput("joint_dp", {24'h0, dp_out}, 32'hFF);
        repeat (5) tick();
        flash_req = 1'b1;
        tick();
        flash_req = 1'b0;
        tick();
        tick();
        checkOutput("pre_reset_dp", {24'h0, dp_out}, 32'hFF);
        checkOutput("pre_reset_digits", {12'h0, score_digits}, 32'h12345);
        checkOutput("pre_reset_ready", {31'h0, score_bus.score_ready}, 32'h0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_hex", all_hex, 32'h0);
        checkOutput("async_reset_dp", {24'h0, dp_out}, 32'hC0);
        checkOutput("async_reset_ready", {31'h0, score_bus.score_ready}, 32'h1);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_reset_digits", {12'h0, score_digits}, 32'h0);

        // Fresh conversion after the abort
        applyStimulus(16'd42, 1'b1, 4'd5, 4'd10, 1'b0);
        tick();
        applyStimulus(16'd42, 1'b0, 4'd5, 4'd10, 1'b0);
        repeat (16) tick();
        checkOutput("busy_42", {31'h0, score_bus.score_ready}, 32'h0);
        tick();
        checkOutput("digits_42", {12'h0, score_digits}, 32'h00042);
        checkOutput("ready_42", {31'h0, score_bus.score_ready}, 32'h1);
        checkOutput("final_hex76", {24'h0, hex7, hex6}, 32'h59);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Controller that feeds the 8-digit seven-segment multiplexer: produces its eight hex digit inputs and the decimal-point vector.
- Accepts a binary game score through a valid/ready handshake and converts it to 5 BCD digits with a sequential double-dabble engine.
- Shows lives and level digits beside the score.
- On request, flashes all decimal points as a hit/level-up indicator.

Parameters:
- SCORE_W, 16, score input width; fixed at 16 (5 BCD digits cover 0..65535).
- FLASH_HALF, 12_500_000, clock cycles per flash phase (0.25 s at 50 MHz).
- FLASH_PHASES, 6, number of flash phases per flash request; even, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- score_in  in  16  binary score.
- score_valid  in  1  score_in is valid.
- score_ready  out  1  controller can accept a score.
- lives_in  in  4  lives count, binary.
- level_in  in  4  level number, binary.
- flash_req  in  1  single-cycle pulse that starts or restarts a flash sequence.
- hex7..hex0  out  4 each  digit values for the display mux.
- dp_out  out  8  decimal points, active-high; bit i belongs to digit i.

Behaviour:
- One clock domain: clk. reset is asynchronous and active-high.
- Reset values:
  - hex7..hex0 = 0.
  - dp_out = 8'b1100_0000 (DP_NORMAL).
  - score_ready = 1.
  - FSM in IDLE, flash inactive, all internal counters 0.
- Digit map:
  - hex7 = lives.
  - hex6 = level.
  - hex5 = 0.
  - hex4..hex0 = score BCD, where hex4 is ten-thousands and hex0 is units.
- Lives/level:
  - Registered each cycle with one-cycle latency.
  - Values >9 clamp to 9.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: score_ready = 1. When score_valid && score_ready at edge T: load score_in into the shift register, clear the 20-bit BCD accumulator and the bit counter, go to SHIFT. score_ready = 0 from edge T.
  - SHIFT: 16 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After the 16th shift, go to COMMIT.
  - COMMIT: copy the accumulator to hex4..hex0 and go to IDLE. score_ready = 1.
- Timing:
  - The accept edge is edge T. The new digits and score_ready = 1 both appear after edge T+17.
  - A back-to-back score with valid held high is accepted at edge T+18.
- score_valid while ready = 0 is ignored. The producer must hold score_in/score_valid until the transfer completes.
- Displayed score digits change only in COMMIT. They never show partial values.
- Flash behaviour:
  - flash_req at edge F loads phase counter = FLASH_PHASES and cycle counter = FLASH_HALF-1.
  - While phase counter ≠ 0: dp_out = 8'hFF on odd remaining-phase counts and DP_NORMAL on even counts. The first phase after the request is therefore 8'hFF.
  - The cycle counter decrements each cycle. At 0 it reloads and the phase counter decrements.
  - When the phase counter reaches 0, dp_out = DP_NORMAL.
  - flash_req during an active flash restarts the sequence from full length.
  - flash_req in the same cycle as a score transfer: both proceed independently.
- Reset mid-conversion or mid-flash: abort immediately and return to the reset values. The displayed score becomes 00000.
- Score 0 displays 00000. Leading zeros are not blanked.

Decomposition:
- Shared include file (score_display_defs) holds:
  - state encodings ST_IDLE / ST_SHIFT / ST_COMMIT.
  - DP_NORMAL = 8'b1100_0000 and DP_FLASH = 8'hFF.
  - BCD_DIGITS = 5.
  - SHIFT_CNT = 16.
- One sub-module, bin2bcd_seq:
  - Implements the start/busy/done double-dabble engine.
  - The top level keeps the handshake, digit registers, clamping and the flash timer.

Test Plan (bench uses FLASH_HALF=4, FLASH_PHASES=2):
- Reset asserted mid-simulation → all hex = 0, dp_out = 8'hC0, score_ready = 1 asynchronously, before the next clk edge.
- score_in=16'd12345 with valid for one cycle → ready low for 17 cycles; after edge T+17, hex4..hex0 = 1,2,3,4,5 and ready = 1.
- score_in=65535, then immediately 0 with valid held high → second transfer at T+18; digits 6,5,5,3,5, then 0,0,0,0,0, each at its COMMIT.
- lives_in=12, level_in=3 → hex7 = 9 and hex6 = 3 one cycle later; hex5 = 0.
- flash_req pulse → dp_out = FF for 4 cycles, then C0; a second pulse at cycle 2 of the flash restarts the sequence with FF for 4 more cycles.
- Reset at SHIFT cycle 8 of conversion of 999 → hex4..hex0 = 0 and ready = 1; a new score of 42 then shows 0,0,0,4,2.
